exe_muldiv_stage: RTL
=====================

// Module: exe_muldiv_stage
// PURPOSE
//  Parametrised multi-cycle execute unit for M-extension ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
//  Sits beside the single-cycle ALU execute stage and is fed with already-bypassed operands from ID.
//  Holds one op at a time behind a valid/ready handshake and presents the result to MEM.
//  Exports a bypass bus in the {data,index,en} format, plus a busy flag for the hazard logic.
// PARAMETERS
//  XLEN         32  operand/result width (>=8, even)
//  MUL_LATENCY  1   1: product computed in one cycle; 0: iterative shift-add, XLEN cycles
//  IDX_W        5   register index width
// PORTS
//  clk            in   1       clock, all state on posedge
//  reset          in   1       asynchronous, active-high
//  in_valid       in   1       ID holds a valid M-op
//  in_ready       out  1       unit can accept an op this cycle
//  in_op          in   3       000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  in_src1        in   XLEN    rs1 value (bypassed)
//  in_src2        in   XLEN    rs2 value (bypassed)
//  in_pc          in   XLEN    instruction PC, carried through
//  in_wreg_index  in   IDX_W   destination register
//  in_wreg_en     in   1       destination write enable
//  flush          in   1       branch flush: kill op in flight
//  out_valid      out  1       result valid for MEM
//  out_ready      in   1       MEM can accept
//  out_result     out  XLEN    result
//  out_pc         out  XLEN    carried PC
//  out_wreg_index out  IDX_W   carried index
//  out_wreg_en    out  1       carried enable
//  busy           out  1       state != IDLE
//  md_bypass      out  XLEN+IDX_W+1  {out_result,out_wreg_index,out_wreg_en & out_valid}
// BEHAVIOUR
//  Reset: state=IDLE; out_valid=0, out_result=0, out_pc=0, out_wreg_index=0, out_wreg_en=0, busy=0.
//  States: IDLE, MUL, DIV, DONE. Accept = in_valid & in_ready & ~flush.
//  in_ready = (state==IDLE) | (state==DONE & out_ready); the DONE->accept path gives back-to-back ops.
//  On accept: latch op, operands, pc, index, enable; signed ops take |operand| and record result sign.
//   MUL ops, MUL_LATENCY=1 -> DONE next edge (out_valid one cycle after the accept edge).
//   MUL ops, MUL_LATENCY=0 -> MUL for XLEN cycles (one bit per cycle, 2*XLEN accumulator), then DONE.
//   DIV ops, divisor==0 -> DONE next edge: quotient = all ones, remainder = dividend.
//   DIVU/REMU never take the overflow path.
//   DIV/REM, dividend==MIN & divisor==-1 -> DONE next edge: quotient = MIN, remainder = 0.
//   Other DIV ops -> DIV for XLEN cycles (restoring, one quotient bit per cycle), then DONE.
//  Sign fix on DIV->DONE: quotient negated if the operand signs differ; remainder takes the dividend's sign.
//  MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits (MULHSU: src1 signed, src2 unsigned).
//  DONE: out_valid=1, outputs stable until out_ready; out_ready & no new accept -> IDLE.
//  flush has priority over everything: any state -> IDLE next edge, out_valid=0 next cycle, no accept that cycle.
//  Iteration counter: log2(XLEN)+1 bits, cleared on accept; no wrap beyond XLEN.
//  md_bypass en bit is 0 unless out_valid; data bits otherwise unspecified.
//  reset asserted mid-operation: immediate return to the reset values, no partial result emitted.
// TESTING
//  DIVU 100/7, out_ready=1 -> out_valid exactly XLEN+1 cycles after accept, result 14; REMU -> 2.
//  DIV -7/2 -> -3 (0xFFFFFFFD); REM -7/2 -> -1; DIV 0x80000000/-1 -> 0x80000000 in 1 cycle.
//  DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, both one cycle after accept.
//  MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF^2 -> 0xFFFFFFFE; run with both MUL_LATENCY values.
//  Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0; release -> back-to-back op accepted same cycle.
//  flush at iteration 10 of a DIV -> IDLE next cycle, no out_valid; in_valid+flush same cycle -> not accepted.

Source files
------------

// File: rtl/exe_muldiv_stage.sv
// exe_muldiv_stage
//   Multi-cycle execute unit for the RISC-V M extension. Accepts one op at a
//   time over a valid/ready handshake, computes it on unsigned magnitudes,
//   applies the result sign at the end, and holds the result for MEM until
//   out_ready. A flush kills whatever is in flight.
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   in_valid / in_ready        issue handshake from ID
//   in_op                      000 MUL .. 111 REMU
//   in_src1, in_src2           bypassed operands
//   in_pc, in_wreg_index/_en   carried through to the output
//   flush                      kill op in flight, blocks accept this cycle
//   out_valid / out_ready      result handshake to MEM
//   out_result, out_pc,
//   out_wreg_index/_en         result and carried fields
//   busy                       unit not idle (hazard logic)
//   md_bypass                  {out_result, out_wreg_index, out_wreg_en & out_valid}
module exe_muldiv_stage #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MUL_LATENCY = 1,
  parameter int unsigned IDX_W       = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic [XLEN-1:0]       in_src1,
  input  logic [XLEN-1:0]       in_src2,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [IDX_W-1:0]      in_wreg_index,
  input  logic                  in_wreg_en,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_result,
  output logic [XLEN-1:0]       out_pc,
  output logic [IDX_W-1:0]      out_wreg_index,
  output logic                  out_wreg_en,
  output logic                  busy,
  output logic [XLEN+IDX_W:0]   md_bypass
);

  localparam int unsigned     CntW    = $clog2(XLEN) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(XLEN);
  localparam logic [XLEN-1:0] MinVal  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e              r_state;
  logic [2:0]          r_op;
  logic [XLEN-1:0]     r_a;         // |src1|: multiplicand
  logic [XLEN-1:0]     r_b;         // |src2|: multiplier / divisor
  logic [2*XLEN-1:0]   r_acc;       // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [CntW-1:0]     r_cnt;
  logic                r_neg;       // product / quotient sign
  logic                r_rneg;      // remainder sign (dividend sign)
  logic                r_fast;      // div-by-zero or overflow: r_acc already holds the answer
  logic [XLEN-1:0]     r_out_result;
  logic [XLEN-1:0]     r_out_pc;
  logic [IDX_W-1:0]    r_out_idx;
  logic                r_out_en;

  // Operand decode at issue
  logic            w_accept, w_is_div, w_s1_signed, w_s2_signed, w_s1_neg, w_s2_neg;
  logic            w_div_zero, w_div_ovf;
  logic [XLEN-1:0] w_abs1, w_abs2;

  assign in_ready    = (r_state == StIdle) | ((r_state == StDone) & out_ready);
  assign w_accept    = in_valid & in_ready & ~flush;
  assign w_is_div    = in_op[2];
  // MULH and MULHSU treat src1 as signed; only MULH treats src2 as signed.
  assign w_s1_signed = w_is_div ? ~in_op[0] : (in_op[1] ^ in_op[0]);
  assign w_s2_signed = w_is_div ? ~in_op[0] : (~in_op[1] & in_op[0]);
  assign w_s1_neg    = w_s1_signed & in_src1[XLEN-1];
  assign w_s2_neg    = w_s2_signed & in_src2[XLEN-1];
  assign w_abs1      = w_s1_neg ? ('0 - in_src1) : in_src1;
  assign w_abs2      = w_s2_neg ? ('0 - in_src2) : in_src2;
  assign w_div_zero  = (in_src2 == '0);
  assign w_div_ovf   = ~in_op[0] & (in_src1 == MinVal) & (in_src2 == '1);

  // One shift-add multiply step: add multiplicand when the low multiplier bit is set.
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next, w_mul_fast, w_mul_mag, w_mul_prod;
  logic [XLEN-1:0]   w_mul_res;
  logic              w_mul_finish;

  assign w_mul_sum    = {1'b0, r_acc[2*XLEN-1:XLEN]} + ({(XLEN+1){r_acc[0]}} & {1'b0, r_a});
  assign w_mul_next   = {w_mul_sum, r_acc[XLEN-1:1]};
  assign w_mul_fast   = {{XLEN{1'b0}}, r_a} * {{XLEN{1'b0}}, r_b};
  assign w_mul_mag    = (MUL_LATENCY != 0) ? w_mul_fast : r_acc;
  assign w_mul_prod   = r_neg ? ('0 - w_mul_mag) : w_mul_mag;
  assign w_mul_res    = (r_op[1:0] == 2'b00) ? w_mul_prod[XLEN-1:0] : w_mul_prod[2*XLEN-1:XLEN];
  assign w_mul_finish = (MUL_LATENCY != 0) || (r_cnt == CntLast);

  // One restoring-division step; bit XLEN of the trial difference is the borrow.
  logic [XLEN:0]     w_div_shift, w_div_trial;
  logic [2*XLEN-1:0] w_div_next;
  logic [XLEN-1:0]   w_quot, w_rem, w_div_res;
  logic              w_div_finish;

  assign w_div_shift  = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_div_trial  = w_div_shift - {1'b0, r_b};
  assign w_div_next   = w_div_trial[XLEN] ? {w_div_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                          : {w_div_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
  assign w_quot       = (r_neg & ~r_fast) ? ('0 - r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
  assign w_rem        = (r_rneg & ~r_fast) ? ('0 - r_acc[2*XLEN-1:XLEN])
                                           : r_acc[2*XLEN-1:XLEN];
  assign w_div_res    = r_op[1] ? w_rem : w_quot;
  assign w_div_finish = r_fast || (r_cnt == CntLast);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_neg        <= 1'b0;
      r_rneg       <= 1'b0;
      r_fast       <= 1'b0;
      r_out_result <= '0;
      r_out_pc     <= '0;
      r_out_idx    <= '0;
      r_out_en     <= 1'b0;
    end else if (flush) begin
      r_state <= StIdle;
    end else if (w_accept) begin
      r_op      <= in_op;
      r_a       <= w_abs1;
      r_b       <= w_abs2;
      r_neg     <= w_s1_neg ^ w_s2_neg;
      r_rneg    <= w_s1_neg;
      r_cnt     <= '0;
      r_fast    <= w_is_div & (w_div_zero | w_div_ovf);
      r_out_pc  <= in_pc;
      r_out_idx <= in_wreg_index;
      r_out_en  <= in_wreg_en;
      if (!w_is_div)       r_acc <= {{XLEN{1'b0}}, w_abs2};
      else if (w_div_zero) r_acc <= {in_src1, {XLEN{1'b1}}};
      else if (w_div_ovf)  r_acc <= {{XLEN{1'b0}}, MinVal};
      else                 r_acc <= {{XLEN{1'b0}}, w_abs1};
      r_state   <= w_is_div ? StDiv : StMul;
    end else begin
      case (r_state)
        StMul: begin
          if (w_mul_finish) begin
            r_out_result <= w_mul_res;
            r_state      <= StDone;
          end else begin
            r_acc <= w_mul_next;
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StDiv: begin
          if (w_div_finish) begin
            r_out_result <= w_div_res;
            r_state      <= StDone;
          end else begin
            r_acc <= w_div_next;
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StDone: begin
          if (out_ready) r_state <= StIdle;
        end
        default: ;
      endcase
    end
  end

  assign out_valid      = (r_state == StDone);
  assign out_result     = r_out_result;
  assign out_pc         = r_out_pc;
  assign out_wreg_index = r_out_idx;
  assign out_wreg_en    = r_out_en;
  assign busy           = (r_state != StIdle);
  assign md_bypass      = {r_out_result, r_out_idx, r_out_en & out_valid};

endmodule
